// File: rtl/game_score_pkg.sv
// Shared types and seven-segment codes for the game score controller.
// Optional debounce is enabled by defining GAME_SCORE_DEBOUNCE_EN.
package game_score_pkg;

    typedef enum logic {
        PLAY = 1'b0,
        OVER = 1'b1
    } state_e;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/game_score_controller_btn_conditioner.sv
// Per-button synchroniser, optional debounce and falling-edge press event.
// Debounce filter is built only when GAME_SCORE_DEBOUNCE_EN is defined.
module btn_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_ni,
    output logic press_o
);

    logic       sync1_q;
    logic       sync2_q;
    logic       lvl_q;
    logic       press_q;
    logic       arm_q;
    logic [1:0] vld_q;
    logic       cond;

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce_cycles
    end

    // arm_q blocks a press that was already held when reset released
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            lvl_q   <= 1'b1;
            press_q <= 1'b0;
            arm_q   <= 1'b0;
            vld_q   <= 2'b00;
        end else begin
            sync1_q <= btn_ni;
            sync2_q <= sync1_q;
            vld_q   <= {vld_q[0], 1'b1};
            arm_q   <= arm_q | (vld_q[1] & sync2_q);
            lvl_q   <= cond;
            press_q <= arm_q & lvl_q & ~cond;
        end
    end

`ifdef GAME_SCORE_DEBOUNCE_EN
    logic       db_q;
    logic       db_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        db_d  = db_q;
        cnt_d = 8'd0;
        if (sync2_q != db_q) begin
            if (cnt_q + 8'd1 == 8'(DEBOUNCE_CYCLES)) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            db_q  <= 1'b1;
            cnt_q <= 8'd0;
        end else begin
            db_q  <= db_d;
            cnt_q <= cnt_d;
        end
    end

    assign cond = db_q;
`else
    assign cond = sync2_q;
`endif

    assign press_o = press_q;

endmodule

// File: rtl/game_score_controller.sv
// Multi-player score keeper: one point per clean press, foul on ties, win at MAX_SCORE.
// Define GAME_SCORE_DEBOUNCE_EN to add the button debounce filter.
module game_score_controller
    import game_score_pkg::*;
#(
    parameter int unsigned N_PLAYERS       = 2,
    parameter int unsigned MAX_SCORE       = 9,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     clear,
    input  logic [N_PLAYERS-1:0]     btn_n,
    output logic [7*N_PLAYERS-1:0]   led,
    output logic [4*N_PLAYERS-1:0]   score,
    output logic [N_PLAYERS-1:0]     winner,
    output logic                     game_over,
    output logic                     foul
);

    logic [N_PLAYERS-1:0] press;
    state_e               state_q, state_d;
    logic [3:0]           score_q [N_PLAYERS];
    logic [3:0]           score_d [N_PLAYERS];
    logic [N_PLAYERS-1:0] winner_q, winner_d;
    logic                 foul_q, foul_d;
    int unsigned          n_press;

    for (genvar g = 0; g < N_PLAYERS; g++) begin : g_btn
        btn_conditioner #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clk_i  (clk),
            .rst_ni (clear),
            .btn_ni (btn_n[g]),
            .press_o(press[g])
        );
    end

    always_comb begin
        state_d  = state_q;
        score_d  = score_q;
        winner_d = winner_q;
        foul_d   = 1'b0;
        n_press  = $countones(press);
        unique case (state_q)
            PLAY: begin
                if (n_press == 1) begin
                    for (int i = 0; i < N_PLAYERS; i++) begin
                        if (press[i]) begin
                            score_d[i] = score_q[i] + 4'd1;
                            if (score_d[i] == 4'(MAX_SCORE)) begin
                                state_d     = OVER;
                                winner_d[i] = 1'b1;
                            end
                        end
                    end
                end else if (n_press > 1) begin
                    foul_d = 1'b1;
                end
            end
            OVER: begin
            end
            default: state_d = PLAY;
        endcase
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q  <= PLAY;
            winner_q <= '0;
            foul_q   <= 1'b0;
            for (int i = 0; i < N_PLAYERS; i++) begin
                score_q[i] <= 4'd0;
            end
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            foul_q   <= foul_d;
            score_q  <= score_d;
        end
    end

    always_comb begin
        for (int i = 0; i < N_PLAYERS; i++) begin
            score[4*i +: 4] = score_q[i];
            led[7*i +: 7]   = seg7(score_q[i]);
        end
    end

    assign winner    = winner_q;
    assign game_over = (state_q == OVER);
    assign foul      = foul_q;

endmodule
